// File: rtl/proc_issue_stage.sv
// Issue stage: two-entry skid buffer with operand forwarding (capture and held), one-cycle latency.
// o_ready is registered (SKID empty) so i_ready never reaches it combinationally; flush/reset empty both entries.
module proc_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ISA_DPTH   = 64,
  parameter int REG_ADDR_W = 5,
  localparam int OPW       = $clog2(ISA_DPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [OPW-1:0]        i_opcode,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic                  i_use_imm,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_fwd_valid,
  input  logic [REG_ADDR_W-1:0] i_fwd_addr,
  input  logic [DATA_WIDTH-1:0] i_fwd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OPW-1:0]        o_opcode,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);

  typedef struct packed {
    logic [OPW-1:0]        opcode;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  use_imm;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t r_state, w_nxt_state;
  entry_t r_main, r_skid;
  entry_t w_nxt_main, w_nxt_skid;
  entry_t w_new, w_main_upd, w_skid_upd;
  logic   r_ready;
  logic   w_accept, w_drain;

  // Register 0 is hardwired, so a writeback to it must never override read data.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_WIDTH-1:0] dat,
    input logic                  f_vld,
    input logic [REG_ADDR_W-1:0] f_addr,
    input logic [DATA_WIDTH-1:0] f_dat
  );
    return (f_vld && (addr == f_addr) && (addr != '0)) ? f_dat : dat;
  endfunction

  assign w_accept = i_valid && r_ready;
  assign w_drain  = o_valid && i_ready;

  always_comb begin
    w_new         = '0;
    w_new.opcode  = i_opcode;
    w_new.rs1     = i_rs1_addr;
    w_new.rs2     = i_rs2_addr;
    w_new.a       = fwd_sel(i_rs1_addr, i_rs1_data, i_fwd_valid, i_fwd_addr, i_fwd_data);
    w_new.b       = i_use_imm ? i_imm
                              : fwd_sel(i_rs2_addr, i_rs2_data, i_fwd_valid, i_fwd_addr, i_fwd_data);
    w_new.use_imm = i_use_imm;
    w_new.rd      = i_rd_addr;
  end

  // Held entries snoop writeback every cycle so a stalled consumer sees late producers.
  always_comb begin
    w_main_upd   = r_main;
    w_main_upd.a = fwd_sel(r_main.rs1, r_main.a, i_fwd_valid, i_fwd_addr, i_fwd_data);
    if (!r_main.use_imm)
      w_main_upd.b = fwd_sel(r_main.rs2, r_main.b, i_fwd_valid, i_fwd_addr, i_fwd_data);
    w_skid_upd   = r_skid;
    w_skid_upd.a = fwd_sel(r_skid.rs1, r_skid.a, i_fwd_valid, i_fwd_addr, i_fwd_data);
    if (!r_skid.use_imm)
      w_skid_upd.b = fwd_sel(r_skid.rs2, r_skid.b, i_fwd_valid, i_fwd_addr, i_fwd_data);
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_main  = w_main_upd;
    w_nxt_skid  = w_skid_upd;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_nxt_state = ONE;
          w_nxt_main  = w_new;
        end
      end
      ONE: begin
        if (w_accept && w_drain) begin
          w_nxt_main = w_new;
        end else if (w_accept) begin
          w_nxt_state = TWO;
          w_nxt_skid  = w_new;
        end else if (w_drain) begin
          w_nxt_state = EMPTY;
        end
      end
      TWO: begin
        if (w_drain) begin
          w_nxt_state = ONE;
          w_nxt_main  = w_skid_upd;
        end
      end
      default: w_nxt_state = EMPTY;
    endcase
    // Data registers are left as computed; only occupancy is cleared on flush.
    if (i_flush)
      w_nxt_state = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ready <= (w_nxt_state != TWO);
      r_main  <= w_nxt_main;
      r_skid  <= w_nxt_skid;
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = (r_state != EMPTY);
  assign o_opcode  = r_main.opcode;
  assign o_data_a  = r_main.a;
  assign o_data_b  = r_main.b;
  assign o_rd_addr = r_main.rd;

endmodule

// File: tb/tb_proc_issue_stage.sv
// Directed bench for proc_issue_stage: inputs change 1ns after each rising edge, outputs checked there too.
module tb_proc_issue_stage;

  localparam int DW  = 32;
  localparam int OPW = 6;
  localparam int AW  = 5;

  logic          i_clk = 1'b0;
  logic          i_rst, i_flush, i_valid, o_ready;
  logic [OPW-1:0] i_opcode, o_opcode;
  logic [AW-1:0] i_rs1_addr, i_rs2_addr, i_rd_addr, i_fwd_addr, o_rd_addr;
  logic [DW-1:0] i_rs1_data, i_rs2_data, i_imm, i_fwd_data, o_data_a, o_data_b;
  logic          i_use_imm, i_fwd_valid, o_valid, i_ready;

  int n_cmp = 0;
  int n_err = 0;

  proc_issue_stage #(.DATA_WIDTH(DW), .ISA_DPTH(64), .REG_ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_use_imm(i_use_imm), .i_rd_addr(i_rd_addr),
    .i_fwd_valid(i_fwd_valid), .i_fwd_addr(i_fwd_addr), .i_fwd_data(i_fwd_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_rd_addr(o_rd_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic offer(input logic [OPW-1:0] op, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                       input logic [DW-1:0] imm, input logic ui, input logic [AW-1:0] rd);
    i_valid    = 1'b1;
    i_opcode   = op;
    i_rs1_addr = a1;
    i_rs1_data = d1;
    i_rs2_addr = a2;
    i_rs2_data = d2;
    i_imm      = imm;
    i_use_imm  = ui;
    i_rd_addr  = rd;
  endtask

  task automatic fwd(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_fwd_valid = v;
    i_fwd_addr  = a;
    i_fwd_data  = d;
  endtask

  initial begin
    logic [DW-1:0] sum;
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    offer(6'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    i_valid = 1'b0;
    fwd(1'b0, 5'd0, 32'd0);

    // Reset values
    step(); step();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_opcode", o_opcode, 0);
    chk("rst_a", o_data_a, 0);
    chk("rst_b", o_data_b, 0);
    chk("rst_rd", o_rd_addr, 0);

    // Single transfer on the first edge with reset low
    i_rst = 1'b0; i_ready = 1'b1;
    offer(6'd0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd9);
    step();
    i_valid = 1'b0;
    chk("single_valid", o_valid, 1);
    chk("single_a", o_data_a, 5);
    chk("single_b", o_data_b, 7);
    chk("single_rd", o_rd_addr, 9);
    sum = o_data_a + o_data_b;
    chk("single_sum", sum, 12);
    step();
    chk("single_drained", o_valid, 0);

    // Stall fill then ordered drain
    i_ready = 1'b0;
    offer(6'd1, 5'd1, 32'h11, 5'd2, 32'h12, 32'd0, 1'b0, 5'd1);
    step();
    chk("fill1_ready", o_ready, 1);
    chk("fill1_rd", o_rd_addr, 1);
    offer(6'd2, 5'd1, 32'h21, 5'd2, 32'h22, 32'd0, 1'b0, 5'd2);
    step();
    chk("fill2_ready", o_ready, 0);
    offer(6'd3, 5'd1, 32'h31, 5'd2, 32'h32, 32'd0, 1'b0, 5'd3);
    step();
    chk("fill3_ready", o_ready, 0);
    chk("fill3_rd", o_rd_addr, 1);
    chk("fill3_a", o_data_a, 32'h11);
    i_ready = 1'b1;
    step();
    chk("drain2_rd", o_rd_addr, 2);
    chk("drain2_op", o_opcode, 2);
    chk("drain2_ready", o_ready, 1);
    step();
    i_valid = 1'b0;
    chk("drain3_rd", o_rd_addr, 3);
    chk("drain3_a", o_data_a, 32'h31);
    chk("drain3_valid", o_valid, 1);
    step();
    chk("drain_empty", o_valid, 0);

    // Forwarding at capture, and address zero never forwarded
    offer(6'd4, 5'd3, 32'h100, 5'd5, 32'h200, 32'd0, 1'b0, 5'd4);
    fwd(1'b1, 5'd3, 32'hDEAD);
    step();
    chk("cap_fwd_a", o_data_a, 32'hDEAD);
    chk("cap_nofwd_b", o_data_b, 32'h200);
    offer(6'd5, 5'd0, 32'h55, 5'd0, 32'h66, 32'd0, 1'b0, 5'd5);
    fwd(1'b1, 5'd0, 32'hBEEF);
    step();
    i_valid = 1'b0;
    fwd(1'b0, 5'd0, 32'd0);
    chk("zero_a", o_data_a, 32'h55);
    chk("zero_b", o_data_b, 32'h66);
    step();
    chk("fwd_empty", o_valid, 0);

    // Held forwarding into SKID; immediate operand unaffected
    i_ready = 1'b0;
    offer(6'd6, 5'd7, 32'h1, 5'd6, 32'h1, 32'd0, 1'b0, 5'd1);
    step();
    offer(6'd7, 5'd8, 32'h2, 5'd4, 32'h20, 32'd0, 1'b0, 5'd2);
    step();
    i_valid = 1'b0;
    fwd(1'b1, 5'd4, 32'd9);
    step();
    fwd(1'b0, 5'd0, 32'd0);
    i_ready = 1'b1;
    step();
    chk("held_rd", o_rd_addr, 2);
    chk("held_b", o_data_b, 9);
    chk("held_a", o_data_a, 32'h2);
    i_ready = 1'b0;
    offer(6'd8, 5'd8, 32'h3, 5'd4, 32'h33, 32'h77, 1'b1, 5'd3);
    step();
    i_valid = 1'b0;
    fwd(1'b1, 5'd4, 32'd9);
    step();
    fwd(1'b0, 5'd0, 32'd0);
    i_ready = 1'b1;
    step();
    chk("imm_rd", o_rd_addr, 3);
    chk("imm_b", o_data_b, 32'h77);
    step();
    chk("imm_empty", o_valid, 0);

    // Flush in state TWO with a simultaneous offer
    i_ready = 1'b0;
    offer(6'd9, 5'd1, 32'hA1, 5'd2, 32'hA2, 32'd0, 1'b0, 5'd1);
    step();
    offer(6'd10, 5'd1, 32'hB1, 5'd2, 32'hB2, 32'd0, 1'b0, 5'd2);
    step();
    chk("flush_pre_ready", o_ready, 0);
    offer(6'd11, 5'd1, 32'hC1, 5'd2, 32'hC2, 32'd0, 1'b0, 5'd7);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_ready, 1);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_stays_empty", o_valid, 0);
    end

    // Reset while stalled in TWO
    i_ready = 1'b0;
    offer(6'd12, 5'd1, 32'hD1, 5'd2, 32'hD2, 32'd0, 1'b0, 5'd1);
    step();
    offer(6'd13, 5'd1, 32'hE1, 5'd2, 32'hE2, 32'd0, 1'b0, 5'd2);
    step();
    i_valid = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_ready", o_ready, 1);
    chk("mrst_opcode", o_opcode, 0);
    chk("mrst_a", o_data_a, 0);
    chk("mrst_b", o_data_b, 0);
    chk("mrst_rd", o_rd_addr, 0);
    offer(6'd14, 5'd1, 32'h42, 5'd2, 32'h43, 32'd0, 1'b0, 5'd5);
    step();
    i_valid = 1'b0;
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_a", o_data_a, 32'h42);
    chk("post_rst_rd", o_rd_addr, 5);
    i_ready = 1'b1;
    step();
    chk("post_rst_empty", o_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_issue_stage.md
PROC_ISSUE_STAGE -- requirements
Module: proc_issue_stage

Interface
REQ-001 Parameter DATA_WIDTH SHALL be defined with default 32: operand and result width.
REQ-002 Parameter ISA_DPTH SHALL be defined with default 64: opcode space, so the opcode width is OPW = $clog2(ISA_DPTH).
REQ-003 Parameter REG_ADDR_W SHALL be defined with default 5: register-address width.
REQ-004 The block SHALL use one clock, i_clk, and one synchronous, active-high reset, i_rst.
REQ-005 Ports (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_flush, in, 1, discard all held and incoming instructions.
- i_valid, in, 1, upstream instruction valid.
- o_ready, out, 1, stage can accept.
- i_opcode, in, OPW, ALU opcode.
- i_rs1_addr and i_rs2_addr, in, REG_ADDR_W each, source registers.
- i_rs1_data and i_rs2_data, in, DATA_WIDTH each, register-file read data.
- i_imm, in, DATA_WIDTH, immediate.
- i_use_imm, in, 1, operand B comes from i_imm.
- i_rd_addr, in, REG_ADDR_W, destination register.
- i_fwd_valid, in, 1, writeback result valid.
- i_fwd_addr, in, REG_ADDR_W, writeback destination.
- i_fwd_data, in, DATA_WIDTH, writeback data.
- o_valid, out, 1, ALU operands valid.
- i_ready, in, 1, ALU/downstream accepts.
- o_opcode, out, OPW, opcode to the ALU.
- o_data_a and o_data_b, out, DATA_WIDTH each, ALU operands.
- o_rd_addr, out, REG_ADDR_W, destination register.

Function
REQ-006 The block SHALL hold up to two entries, MAIN and SKID; each entry stores opcode, rs1/rs2 addresses, operand A, operand B, use_imm and rd.
REQ-007 An upstream transfer SHALL occur when i_valid and o_ready are both high at the clock edge.
REQ-008 A downstream transfer SHALL occur when o_valid and i_ready are both high at the clock edge.
REQ-009 o_ready SHALL be a register output and SHALL equal "SKID empty"; there is no combinational path from i_ready to o_ready.
REQ-010 o_valid SHALL equal "MAIN full", and the o_* data outputs SHALL be driven directly from MAIN registers.
REQ-011 State encoding SHALL be EMPTY (no entries), ONE (MAIN only) and TWO (MAIN+SKID); transitions are as follows.
- EMPTY + accept -> ONE.
- ONE + accept, no drain -> TWO.
- ONE + drain, no accept -> EMPTY.
- ONE + accept + drain -> ONE, with MAIN replaced by the new entry.
- TWO + drain -> ONE, with SKID moving to MAIN.
- TWO never accepts.
REQ-012 Latency SHALL be one cycle: an entry accepted at edge N is visible on o_* after edge N when MAIN was empty or drained at edge N.
REQ-013 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-014 Operand A at capture SHALL be i_rs1_data, unless i_fwd_valid is set and i_fwd_addr equals i_rs1_addr and is nonzero, in which case it is i_fwd_data.
REQ-015 Operand B at capture SHALL be i_imm when i_use_imm=1; otherwise it follows the same forwarding rule as operand A, using rs2.
REQ-016 On every cycle with i_fwd_valid=1, held MAIN and SKID entries SHALL also update operand A and operand B (B only when use_imm=0) whose stored source address matches a nonzero i_fwd_addr.
REQ-017 Register address 0 SHALL never be forwarded, and its data passes through unchanged.
REQ-018 Flush SHALL take priority over accept and drain: on an edge with i_flush=1, both entries are invalidated, the next state is EMPTY, o_ready=1 and o_valid=0, and any upstream transfer in that cycle is discarded.
REQ-019 Data registers SHALL NOT require clearing on flush, and their values while o_valid=0 are don't-care except after reset.
REQ-020 o_opcode and operands SHALL pass through unmodified, with no arithmetic performed in this block, and all widths SHALL be exact with no truncation.

Reset
REQ-021 While i_rst is high at an edge, the state SHALL become EMPTY, o_valid=0, o_ready=1, and o_opcode, o_data_a, o_data_b and o_rd_addr SHALL be 0.
REQ-022 Reset SHALL take priority over flush, accept, drain and forwarding, and a reset asserted mid-stall SHALL discard both held entries.
REQ-023 The first accept SHALL be possible on the first edge with i_rst low.

Verification
REQ-024 Single transfer: i_valid=1, i_opcode=0, rs1 data 5, rs2 data 7, i_use_imm=0, i_ready=1 -> next cycle o_valid=1, o_data_a=5, o_data_b=7, and the ALU result is 12.
REQ-025 Stall fill: i_ready=0 while three instructions are offered on consecutive cycles -> the first two are accepted, o_ready=0 after the second, and the third is held upstream; with i_ready=1, outputs drain in order 1, 2, 3.
REQ-026 Forwarding:
- Capture: i_rs1_addr=3 with i_fwd_valid=1, i_fwd_addr=3, i_fwd_data=0xDEAD -> o_data_a=0xDEAD.
- Address zero: i_rs1_addr=0 with i_fwd_addr=0 -> o_data_a = i_rs1_data.
REQ-027 Held forwarding: entry stalled in SKID with rs2=4, then i_fwd_valid=1, i_fwd_addr=4, i_fwd_data=9 -> when the entry reaches MAIN, o_data_b=9; with use_imm=1, o_data_b stays at the immediate.
REQ-028 Flush: state TWO with i_flush=1 and i_valid=1 in the same cycle -> next cycle o_valid=0 and o_ready=1, and no flushed or incoming entry ever appears on the outputs.
REQ-029 Reset mid-operation: state TWO, then i_rst=1 for one cycle -> o_valid=0, o_ready=1 and all o_* data are 0; a following accept yields normal one-cycle latency.
